// File: rtl/reservation_station_queue_pkg.sv
// Shared Tomasulo types for the reservation station queue and its neighbours.
// Contents: ROB sizing constants, opcode enum, dispatch word (res_word),
// ALU issue word (alu_word) and the per-tag CDB payload (cdb_data).
package tomasula_types;

  localparam int ROB_SIZE_DEF = 8;
  localparam int ROB_TAG_W    = $clog2(ROB_SIZE_DEF);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    rob_tag_t    src1_tag;
    logic        src1_valid;
    logic [31:0] src1_data;
    rob_tag_t    src2_tag;
    logic        src2_valid;
    logic [31:0] src2_data;
    rob_tag_t    rd_tag;
    logic [31:0] pc;
  } res_word;

  typedef struct packed {
    op_t         op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
    rob_tag_t    tag;
    logic [31:0] pc;
  } alu_word;

  typedef struct packed {
    logic [31:0] data;
  } cdb_data;

endpackage

// File: rtl/reservation_station_queue_wakeup.sv
// rs_entry_wakeup: per-slot operand capture and ready computation.
// Ports:
//   valid                 slot holds an entry
//   entry                 registered slot contents
//   cdb, robs_calculated  per-tag result data and its valid mask
//   allocated_rob_entries bit clear = tag flushed
//   woken                 entry with any CDB hit merged in; doubles as the
//                         same-cycle bypassed operand view for issue
//   live                  valid and not flushed (survives this cycle)
//   ready                 live with both operands available this cycle
module rs_entry_wakeup
  import tomasula_types::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic                valid,
  input  res_word             entry,
  input  cdb_data             cdb [ROB_SIZE],
  input  logic [ROB_SIZE-1:0] robs_calculated,
  input  logic [ROB_SIZE-1:0] allocated_rob_entries,
  output res_word             woken,
  output logic                live,
  output logic                ready
);

  logic [TAG_W-1:0] t1, t2, trd;

  always_comb begin
    t1    = entry.src1_tag;
    t2    = entry.src2_tag;
    trd   = entry.rd_tag;
    woken = entry;
    if (!entry.src1_valid && robs_calculated[t1]) begin
      woken.src1_valid = 1'b1;
      woken.src1_data  = cdb[t1].data;
    end
    if (!entry.src2_valid && robs_calculated[t2]) begin
      woken.src2_valid = 1'b1;
      woken.src2_data  = cdb[t2].data;
    end
    live  = valid & allocated_rob_entries[trd];
    ready = live & woken.src1_valid & woken.src2_valid;
  end

endmodule

// File: rtl/reservation_station_queue.sv
// reservation_station_queue: DEPTH-entry collapsing reservation station in
// front of one ALU. Slot 0 is the oldest entry; valid slots are contiguous.
// Ports:
//   load_word/res_in      dispatch (ignored while full)
//   cdb/robs_calculated   result broadcast used for wakeup and bypass
//   allocated_rob_entries clear bit flushes every entry with that rd_tag
//   exe_ready/start_exe/alu_data  issue handshake to the ALU
//   jalr_executed, ld_pc_to_cdb, update_br  decoded from the issuing op
//   res_empty, full, count       occupancy from registered state only
// Handshake: start_exe is valid, exe_ready is ready; an entry leaves only on
// the edge where both are high. While stalled the oldest ready entry stays
// selected unless an older one becomes ready, so alu_data may change.
module reservation_station_queue
  import tomasula_types::*;
#(
  parameter int DEPTH    = 4,
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_word,
  input  res_word                    res_in,
  input  cdb_data                    cdb [ROB_SIZE],
  input  logic [ROB_SIZE-1:0]        robs_calculated,
  input  logic [ROB_SIZE-1:0]        allocated_rob_entries,
  input  logic                       exe_ready,
  output alu_word                    alu_data,
  output logic                       start_exe,
  output logic                       jalr_executed,
  output logic                       ld_pc_to_cdb,
  output logic                       update_br,
  output logic                       res_empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  res_word              slot_q   [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  res_word              woken    [DEPTH];
  res_word              nxt_slot [DEPTH];
  logic [DEPTH-1:0]     nxt_vld;
  logic [DEPTH-1:0]     live, rdy, keep;
  res_word              in_woken;
  logic [CNT_W-1:0]     cnt, pos;
  logic [SEL_W-1:0]     sel;
  logic                 fire, accept;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    rs_entry_wakeup #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_wakeup (
      .valid                 (vld_q[g]),
      .entry                 (slot_q[g]),
      .cdb                   (cdb),
      .robs_calculated       (robs_calculated),
      .allocated_rob_entries (allocated_rob_entries),
      .woken                 (woken[g]),
      .live                  (live[g]),
      .ready                 (rdy[g])
    );
  end

  // A dispatched word captures anything broadcast in its dispatch cycle,
  // otherwise that result would be missed forever.
  always_comb begin
    in_woken = res_in;
    if (!res_in.src1_valid && robs_calculated[res_in.src1_tag]) begin
      in_woken.src1_valid = 1'b1;
      in_woken.src1_data  = cdb[res_in.src1_tag].data;
    end
    if (!res_in.src2_valid && robs_calculated[res_in.src2_tag]) begin
      in_woken.src2_valid = 1'b1;
      in_woken.src2_data  = cdb[res_in.src2_tag].data;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(vld_q[i]);
  end

  assign count     = cnt;
  assign full      = (cnt == CNT_W'(DEPTH));
  assign res_empty = (cnt == '0);

  // Oldest-ready select: lowest slot index wins.
  always_comb begin
    sel       = '0;
    start_exe = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !start_exe) begin
        start_exe = 1'b1;
        sel       = SEL_W'(i);
      end
    end
  end

  always_comb begin
    alu_data      = '0;
    jalr_executed = 1'b0;
    ld_pc_to_cdb  = 1'b0;
    update_br     = 1'b0;
    if (start_exe) begin
      alu_data.op        = woken[sel].op;
      alu_data.funct3    = (woken[sel].op == OP_JAL || woken[sel].op == OP_JALR)
                           ? 3'b000 : woken[sel].funct3;
      alu_data.funct7    = woken[sel].funct7;
      alu_data.src1_data = woken[sel].src1_data;
      alu_data.src2_data = woken[sel].src2_data;
      alu_data.tag       = woken[sel].rd_tag;
      alu_data.pc        = woken[sel].pc;
      jalr_executed      = (woken[sel].op == OP_JALR);
      update_br          = (woken[sel].op == OP_BR);
      ld_pc_to_cdb       = (woken[sel].op == OP_JAL)   || (woken[sel].op == OP_JALR) ||
                           (woken[sel].op == OP_BR)    || (woken[sel].op == OP_AUIPC) ||
                           (woken[sel].op == OP_LUI);
    end
  end

  assign fire   = start_exe & exe_ready;
  assign accept = load_word & ~full;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      keep[i] = live[i] & ~(fire && (sel == SEL_W'(i)));
  end

  // Compaction: survivors are packed down in age order, then the new
  // dispatch lands right after the last survivor.
  always_comb begin
    pos     = '0;
    nxt_vld = '0;
    for (int k = 0; k < DEPTH; k++) nxt_slot[k] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (pos == CNT_W'(k)) begin
            nxt_slot[k] = woken[i];
            nxt_vld[k]  = 1'b1;
          end
        end
        pos = pos + 1'b1;
      end
    end
    if (accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (pos == CNT_W'(k)) begin
          nxt_slot[k] = in_woken;
          nxt_vld[k]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      vld_q <= nxt_vld;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= nxt_slot[i];
    end
  end

endmodule

// File: tb/tb_reservation_station_queue.sv
// Directed bench for reservation_station_queue: expected issues are pushed
// into exp_q when stimulus is applied; a negedge monitor pops one entry per
// fire and compares alu_data plus sidebands. Status outputs are checked
// directly at negedge.
module tb_reservation_station_queue;
  import tomasula_types::*;

  localparam int DEPTH = 4;
  localparam int ROB   = 8;
  localparam int EXP_W = $bits(alu_word) + 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                load_word;
  res_word             res_in;
  cdb_data             cdb [ROB];
  logic [ROB-1:0]      robs_calculated;
  logic [ROB-1:0]      allocated_rob_entries;
  logic                exe_ready;
  alu_word             alu_data;
  logic                start_exe, jalr_executed, ld_pc_to_cdb, update_br;
  logic                res_empty, full;
  logic [2:0]          count;

  int vectors     = 0;
  int miscompares = 0;
  logic [EXP_W-1:0] exp_q[$];

  reservation_station_queue #(.DEPTH(DEPTH), .ROB_SIZE(ROB)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_word             (load_word),
    .res_in                (res_in),
    .cdb                   (cdb),
    .robs_calculated       (robs_calculated),
    .allocated_rob_entries (allocated_rob_entries),
    .exe_ready             (exe_ready),
    .alu_data              (alu_data),
    .start_exe             (start_exe),
    .jalr_executed         (jalr_executed),
    .ld_pc_to_cdb          (ld_pc_to_cdb),
    .update_br             (update_br),
    .res_empty             (res_empty),
    .full                  (full),
    .count                 (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic res_word mk(op_t op, logic [2:0] f3,
                                 rob_tag_t t1, logic v1, logic [31:0] d1,
                                 rob_tag_t t2, logic v2, logic [31:0] d2,
                                 rob_tag_t rd, logic [31:0] pc);
    res_word w;
    w.op = op; w.funct3 = f3; w.funct7 = 7'd0;
    w.src1_tag = t1; w.src1_valid = v1; w.src1_data = d1;
    w.src2_tag = t2; w.src2_valid = v2; w.src2_data = d2;
    w.rd_tag = rd; w.pc = pc;
    return w;
  endfunction

  function automatic logic [EXP_W-1:0] ex(op_t op, logic [2:0] f3,
                                          logic [31:0] d1, logic [31:0] d2,
                                          rob_tag_t rd, logic [31:0] pc,
                                          logic j, logic l, logic b);
    alu_word a;
    a.op = op; a.funct3 = f3; a.funct7 = 7'd0;
    a.src1_data = d1; a.src2_data = d2; a.tag = rd; a.pc = pc;
    return {a, j, l, b};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d pending issues required 0", name, exp_q.size());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (start_exe && exe_ready) begin
      logic [EXP_W-1:0] act, exp;
      act = {alu_data, jalr_executed, ld_pc_to_cdb, update_br};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL issue_unexpected: got %h required no issue", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          miscompares++;
          $display("FAIL issue: got %h required %h", act, exp);
        end
      end
    end
  end

  res_word e [4];

  initial begin
    rst = 1'b1;
    load_word = 1'b1;
    res_in = mk(OP_REG, 3'd0, 3'd0, 1'b1, 32'h9, 3'd0, 1'b1, 32'h9, 3'd1, 32'h0);
    robs_calculated = '0;
    allocated_rob_entries = '1;
    exe_ready = 1'b1;
    for (int i = 0; i < ROB; i++) cdb[i].data = 32'h0;

    // reset with load_word held high
    step(); step();
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_start", start_exe, 0);
    step();
    rst = 1'b0;
    load_word = 1'b0;
    @(negedge clk);
    check("rst_count_after", count, 0);
    check("rst_empty", res_empty, 1);
    check("rst_full", full, 0);
    check("rst_start_after", start_exe, 0);
    check("rst_sideband", {jalr_executed, ld_pc_to_cdb, update_br}, 0);

    // single ready ADD
    step();
    res_in = mk(OP_REG, 3'd0, 3'd0, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd1, 32'h100);
    load_word = 1'b1;
    exp_q.push_back(ex(OP_REG, 3'd0, 32'd5, 32'd7, 3'd1, 32'h100, 0, 0, 0));
    @(negedge clk);
    check("dispatch_no_bypass", start_exe, 0);
    step();
    load_word = 1'b0;
    @(negedge clk);
    check("add_start", start_exe, 1);
    check("add_count", count, 1);
    step();
    @(negedge clk);
    check("add_count_after", count, 0);
    check("add_empty_after", res_empty, 1);

    // A waits on tag 3, B ready: B first, then A by CDB bypass
    step();
    res_in = mk(OP_IMM, 3'b111, 3'd3, 1'b0, 32'h0, 3'd0, 1'b1, 32'h11, 3'd2, 32'h110);
    load_word = 1'b1;
    step();
    res_in = mk(OP_REG, 3'b100, 3'd0, 1'b1, 32'hA, 3'd0, 1'b1, 32'hB, 3'd4, 32'h114);
    exp_q.push_back(ex(OP_REG, 3'b100, 32'hA, 32'hB, 3'd4, 32'h114, 0, 0, 0));
    step();
    load_word = 1'b0;
    @(negedge clk);
    check("ab_count", count, 2);
    step();
    robs_calculated[3] = 1'b1;
    cdb[3].data = 32'h20;
    exp_q.push_back(ex(OP_IMM, 3'b111, 32'h20, 32'h11, 3'd2, 32'h110, 0, 0, 0));
    @(negedge clk);
    check("a_bypass_start", start_exe, 1);
    check("a_bypass_count", count, 1);
    step();
    robs_calculated = '0;
    @(negedge clk);
    check("ab_drained", count, 0);

    // fill with waiting entries, reject loads while full
    for (int i = 0; i < 4; i++)
      e[i] = mk(OP_REG, 3'd0, rob_tag_t'((i < 2) ? 5 + i : 7), 1'b0, 32'h0,
                3'd0, 1'b1, 32'(i + 1), rob_tag_t'(i), 32'h200 + 32'(4 * i));
    step();
    for (int i = 0; i < 4; i++) begin
      res_in = e[i];
      load_word = 1'b1;
      step();
    end
    res_in = mk(OP_REG, 3'd0, 3'd0, 1'b1, 32'h1, 3'd0, 1'b1, 32'h2, 3'd4, 32'h300);
    @(negedge clk);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    step();
    load_word = 1'b0;
    @(negedge clk);
    check("full_reject_count", count, 4);
    step();
    // wake E0 and fire while full: dispatch of F must be rejected
    robs_calculated[5] = 1'b1;
    cdb[5].data = 32'h55;
    load_word = 1'b1;
    exp_q.push_back(ex(OP_REG, 3'd0, 32'h55, 32'd1, 3'd0, 32'h200, 0, 0, 0));
    @(negedge clk);
    check("full_fire_start", start_exe, 1);
    step();
    // not full: fire E1 and dispatch G together
    robs_calculated = '0;
    robs_calculated[6] = 1'b1;
    cdb[6].data = 32'h66;
    res_in = mk(OP_REG, 3'd0, 3'd4, 1'b0, 32'h0, 3'd0, 1'b1, 32'h9, 3'd4, 32'h310);
    exp_q.push_back(ex(OP_REG, 3'd0, 32'h66, 32'd2, 3'd1, 32'h204, 0, 0, 0));
    @(negedge clk);
    check("full_fire_reject_count", count, 3);
    step();
    load_word = 1'b0;
    robs_calculated = '0;
    @(negedge clk);
    check("fire_plus_load_count", count, 3);
    step();
    robs_calculated[7] = 1'b1;
    robs_calculated[4] = 1'b1;
    cdb[7].data = 32'h77;
    cdb[4].data = 32'h44;
    exp_q.push_back(ex(OP_REG, 3'd0, 32'h77, 32'd3, 3'd2, 32'h208, 0, 0, 0));
    exp_q.push_back(ex(OP_REG, 3'd0, 32'h77, 32'd4, 3'd3, 32'h20C, 0, 0, 0));
    exp_q.push_back(ex(OP_REG, 3'd0, 32'h44, 32'h9, 3'd4, 32'h310, 0, 0, 0));
    step();
    robs_calculated = '0;
    wait_drain("fill_drain");
    @(negedge clk);
    check("fill_count_end", count, 0);

    // stalled JALR with a BRANCH behind it
    step();
    exe_ready = 1'b0;
    res_in = mk(OP_JALR, 3'b010, 3'd0, 1'b1, 32'h1000, 3'd0, 1'b1, 32'h0, 3'd5, 32'h400);
    load_word = 1'b1;
    step();
    res_in = mk(OP_BR, 3'b001, 3'd0, 1'b1, 32'd3, 3'd0, 1'b1, 32'd4, 3'd6, 32'h404);
    step();
    load_word = 1'b0;
    @(negedge clk);
    check("jalr_start", start_exe, 1);
    check("jalr_sideband", {jalr_executed, ld_pc_to_cdb, update_br}, 3'b110);
    check("jalr_funct3", alu_data.funct3, 0);
    check("jalr_src1", alu_data.src1_data, 32'h1000);
    step();
    @(negedge clk);
    check("jalr_hold_start", start_exe, 1);
    check("jalr_hold_tag", alu_data.tag, 5);
    check("jalr_hold_count", count, 2);
    step();
    exe_ready = 1'b1;
    exp_q.push_back(ex(OP_JALR, 3'b000, 32'h1000, 32'h0, 3'd5, 32'h400, 1, 1, 0));
    step();
    exe_ready = 1'b0;
    @(negedge clk);
    check("jalr_one_removal", count, 1);
    check("br_sideband", {jalr_executed, ld_pc_to_cdb, update_br}, 3'b011);
    step();
    exe_ready = 1'b1;
    exp_q.push_back(ex(OP_BR, 3'b001, 32'd3, 32'd4, 3'd6, 32'h404, 0, 1, 1));
    step();
    @(negedge clk);
    check("br_count_after", count, 0);

    // flush slots 0 and 2 of four waiting entries
    for (int i = 0; i < 4; i++)
      e[i] = mk(OP_IMM, 3'(i), 3'd7, 1'b0, 32'h0, 3'd0, 1'b1, 32'h10 + 32'(i),
                rob_tag_t'(i), 32'h500 + 32'(4 * i));
    step();
    for (int i = 0; i < 4; i++) begin
      res_in = e[i];
      load_word = 1'b1;
      step();
    end
    load_word = 1'b0;
    allocated_rob_entries = 8'b1111_1010;
    @(negedge clk);
    check("flush_pre_count", count, 4);
    check("flush_no_issue", start_exe, 0);
    step();
    allocated_rob_entries = '1;
    @(negedge clk);
    check("flush_count", count, 2);
    step();
    robs_calculated[7] = 1'b1;
    cdb[7].data = 32'h70;
    exp_q.push_back(ex(OP_IMM, 3'd1, 32'h70, 32'h11, 3'd1, 32'h504, 0, 0, 0));
    exp_q.push_back(ex(OP_IMM, 3'd3, 32'h70, 32'h13, 3'd3, 32'h50C, 0, 0, 0));
    step();
    robs_calculated = '0;
    wait_drain("flush_drain");
    @(negedge clk);
    check("flush_count_end", count, 0);
    check("flush_empty_end", res_empty, 1);

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
